// File: rtl/axi4s_to_video_out.sv
// AXI4-Stream to raster video output: locks to SOF, then generates h/v timing
// and presents one pixel per active cycle, flagging underflow and loss of frame alignment.
module axi4s_to_video_out #(
   parameter int AXI4S_USER_WIDTH = 1,
   parameter int AXI4S_DATA_WIDTH = 24,
   parameter int H_WIDTH          = 12,
   parameter int V_WIDTH          = 12
) (
   input  logic                        aresetn,
   input  logic                        aclk,

   input  logic                        ctl_enable,
   output logic                        ctl_busy,

   input  logic [H_WIDTH-1:0]          param_htotal,
   input  logic [H_WIDTH-1:0]          param_hdisp,
   input  logic [H_WIDTH-1:0]          param_hsync_start,
   input  logic [H_WIDTH-1:0]          param_hsync_end,
   input  logic [V_WIDTH-1:0]          param_vtotal,
   input  logic [V_WIDTH-1:0]          param_vdisp,
   input  logic [V_WIDTH-1:0]          param_vsync_start,
   input  logic [V_WIDTH-1:0]          param_vsync_end,

   input  logic [AXI4S_USER_WIDTH-1:0] s_axi4s_tuser,
   input  logic                        s_axi4s_tlast,
   input  logic [AXI4S_DATA_WIDTH-1:0] s_axi4s_tdata,
   input  logic                        s_axi4s_tvalid,
   output logic                        s_axi4s_tready,

   output logic                        out_vsync,
   output logic                        out_hsync,
   output logic                        out_de,
   output logic [AXI4S_DATA_WIDTH-1:0] out_data,

   output logic                        status_underflow,
   output logic                        status_sync_err
);

   localparam logic [H_WIDTH-1:0]          H_ONE  = {{(H_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [V_WIDTH-1:0]          V_ONE  = {{(V_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [H_WIDTH-1:0]          H_ZERO = {H_WIDTH{1'b0}};
   localparam logic [V_WIDTH-1:0]          V_ZERO = {V_WIDTH{1'b0}};
   localparam logic [AXI4S_DATA_WIDTH-1:0] D_ZERO = {AXI4S_DATA_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t               r_state;
   logic [H_WIDTH-1:0]   r_h;
   logic [V_WIDTH-1:0]   r_v;

   logic w_run;
   logic w_sof;
   logic w_active;
   logic w_misalign;
   logic w_h_last;
   logic w_v_last;
   logic w_hsync;
   logic w_vsync;
   logic w_unused_inputs;

   // Raster decode from the current counters
   always_comb begin
      w_run      = (r_state == ST_RUN);
      w_sof      = s_axi4s_tuser[0];
      w_active   = w_run && (r_h < param_hdisp) && (r_v < param_vdisp);
      w_misalign = w_run && (r_h == H_ZERO) && (r_v == V_ZERO) && s_axi4s_tvalid && !w_sof;
      w_h_last   = (r_h == (param_htotal - H_ONE));
      w_v_last   = (r_v == (param_vtotal - V_ONE));
      w_hsync    = w_run && (r_h >= param_hsync_start) && (r_h < param_hsync_end);
      w_vsync    = w_run && (r_v >= param_vsync_start) && (r_v < param_vsync_end);
      w_unused_inputs = ^{s_axi4s_tlast, s_axi4s_tuser};
   end

   // Stream handshake and busy flag; a misaligned beat at the frame origin is left in place
   always_comb begin
      ctl_busy = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: s_axi4s_tready = 1'b0;
         ST_SYNC: s_axi4s_tready = !w_sof;
         ST_RUN:  s_axi4s_tready = w_active && !w_misalign;
         default: s_axi4s_tready = 1'b0;
      endcase
   end

   // Control FSM, raster counters, registered video outputs and sticky status
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state          <= ST_IDLE;
         r_h              <= H_ZERO;
         r_v              <= V_ZERO;
         out_vsync        <= 1'b0;
         out_hsync        <= 1'b0;
         out_de           <= 1'b0;
         out_data         <= D_ZERO;
         status_underflow <= 1'b0;
         status_sync_err  <= 1'b0;
      end else begin
         out_de    <= w_active && !w_misalign;
         out_data  <= (w_active && s_axi4s_tvalid && !w_misalign) ? s_axi4s_tdata : D_ZERO;
         out_hsync <= w_hsync;
         out_vsync <= w_vsync;
         if (w_active && !s_axi4s_tvalid) begin
            status_underflow <= 1'b1;
         end
         if (w_misalign) begin
            status_sync_err <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_h <= H_ZERO;
               r_v <= V_ZERO;
               if (ctl_enable) begin
                  r_state <= ST_SYNC;
               end
            end
            ST_SYNC: begin
               r_h <= H_ZERO;
               r_v <= V_ZERO;
               if (!ctl_enable) begin
                  r_state <= ST_IDLE;
               end else if (s_axi4s_tvalid && w_sof) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_misalign) begin
                  r_state <= ST_SYNC;
                  r_h     <= H_ZERO;
                  r_v     <= V_ZERO;
               end else if (w_h_last) begin
                  r_h <= H_ZERO;
                  if (w_v_last) begin
                     r_v <= V_ZERO;
                     if (!ctl_enable) begin
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_v <= r_v + V_ONE;
                  end
               end else begin
                  r_h <= r_h + H_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_h     <= H_ZERO;
               r_v     <= V_ZERO;
            end
         endcase
      end
   end

endmodule
